// File: rtl/dm_lsu.sv
// Data memory with an integrated load/store front end: alignment check, lane
// enables, store replication, load extension and a fixed wait-state handshake.
module dm_lsu #(
  parameter int ADDR_W  = 13,
  parameter int LATENCY = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req,
  input  logic              We,
  input  logic [1:0]        Size,
  input  logic              Uns,
  input  logic [ADDR_W-1:0] A,
  input  logic [31:0]       WD,
  output logic              Ready,
  output logic              Done,
  output logic              Err,
  output logic [31:0]       RD
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic              we_q, uns_q, err_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wd_q;
  logic [3:0]        cnt;

  // NOTE: the array is zero at power-up only; it has no reset so it maps to block RAM.
  logic [31:0] mem [DEPTH] = '{default: 32'h0};

  logic        misaligned;
  logic        access_edge;
  logic        commit;
  logic [3:0]  be;
  logic [31:0] wdata, word_rd, shifted, load_ext;

  always_comb begin
    misaligned = 1'b0;
    case (Size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = A[0];
      2'b10:   misaligned = |A[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  assign access_edge = (state == BUSY) && (cnt == 4'd0);
  assign commit      = access_edge && we_q && !err_q && !Reset;

  always_comb begin
    be    = 4'b1111;
    wdata = wd_q;
    case (size_q)
      2'b00: begin
        be    = 4'b0001 << addr_q[1:0];
        wdata = {4{wd_q[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << addr_q[1:0];
        wdata = {2{wd_q[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = wd_q;
      end
    endcase
  end

  // Selected lane is shifted down to bit 0 before extension.
  always_comb begin
    word_rd  = mem[addr_q[ADDR_W-1:2]];
    shifted  = word_rd >> {addr_q[1:0], 3'b000};
    load_ext = word_rd;
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'h0, shifted[7:0]}
                                : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = uns_q ? {16'h0, shifted[15:0]}
                                : {{16{shifted[15]}}, shifted[15:0]};
      default: load_ext = word_rd;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr_q[ADDR_W-1:2]][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      Ready  <= 1'b1;
      Done   <= 1'b0;
      Err    <= 1'b0;
      RD     <= 32'h0;
      we_q   <= 1'b0;
      uns_q  <= 1'b0;
      err_q  <= 1'b0;
      size_q <= 2'b00;
      addr_q <= '0;
      wd_q   <= 32'h0;
      cnt    <= 4'd0;
    end else begin
      Done <= 1'b0;
      Err  <= 1'b0;
      case (state)
        IDLE: begin
          if (Req) begin
            we_q   <= We;
            size_q <= Size;
            uns_q  <= Uns;
            addr_q <= A;
            wd_q   <= WD;
            err_q  <= misaligned;
            cnt    <= 4'(LATENCY);
            Ready  <= 1'b0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (!err_q && !we_q) RD <= load_ext;
            Done  <= 1'b1;
            Err   <= err_q;
            Ready <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_lsu.sv
// Randomised and directed bench for dm_lsu at LATENCY 1, 0, 3 and 15, checked
// against a byte-addressed reference memory.
module tb_dm_lsu;

  localparam int NI = 4;
  localparam int LATS [NI] = '{1, 0, 3, 15};

  logic        Clk = 1'b0;
  logic        Reset;
  logic        req [NI];
  logic        we  [NI];
  logic        uns [NI];
  logic [1:0]  size [NI];
  logic [12:0] a   [NI];
  logic [31:0] wd  [NI];
  logic        ready [NI];
  logic        done  [NI];
  logic        err   [NI];
  logic [31:0] rd    [NI];

  always #5 Clk = ~Clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dm_lsu #(.ADDR_W(13), .LATENCY(LATS[g])) u_dut (
      .Clk(Clk), .Reset(Reset), .Req(req[g]), .We(we[g]), .Size(size[g]),
      .Uns(uns[g]), .A(a[g]), .WD(wd[g]), .Ready(ready[g]), .Done(done[g]),
      .Err(err[g]), .RD(rd[g])
    );
  end

  logic [7:0]  mbyte [NI][8192];
  logic [31:0] model_rd [NI];
  int nvec = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input int k, input logic [1:0] sz,
                                             input bit u, input logic [12:0] ad);
    longint v = 0;
    int nb = 1 << sz;
    for (int i = 0; i < nb; i++) v = v | (longint'(mbyte[k][int'(ad) + i]) << (8 * i));
    if (nb < 4 && !u && v[8*nb-1]) v = v - (longint'(1) << (8 * nb));
    return v[31:0];
  endfunction

  task automatic model_store(input int k, input logic [1:0] sz,
                             input logic [12:0] ad, input logic [31:0] d);
    int nb = 1 << sz;
    for (int i = 0; i < nb; i++) mbyte[k][int'(ad) + i] = d[8*i +: 8];
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    while (!ready[k] && n < 40) begin
      @(posedge Clk); #1;
      n++;
    end
    if (!ready[k]) check("idle_timeout", 32'(ready[k]), 1);
  endtask

  task automatic access(input int k, input bit w, input logic [1:0] sz, input bit u,
                        input logic [12:0] ad, input logic [31:0] d,
                        output logic [31:0] o_rd, output logic o_err);
    int  n = 0;
    bit  seen = 0;
    bit  exp_err;
    int  nb = 1 << sz;
    wait_idle(k);
    @(negedge Clk);
    req[k] = 1'b1; we[k] = w; size[k] = sz; uns[k] = u; a[k] = ad; wd[k] = d;
    @(posedge Clk); #1;
    req[k] = 1'b0;
    check("ready_fall", 32'(ready[k]), 0);
    while (!seen && n < 40) begin
      @(posedge Clk); #1;
      n++;
      if (done[k]) seen = 1;
      else check("busy_ready", 32'(ready[k]), 0);
    end
    o_rd = rd[k];
    o_err = err[k];
    if (!seen) begin
      check("done_timeout", 32'(done[k]), 1);
      return;
    end
    check("done_latency", n, LATS[k] + 1);
    check("done_ready", 32'(ready[k]), 1);
    exp_err = (sz == 2'b11) || ((int'(ad) % nb) != 0);
    check("err", 32'(err[k]), 32'(exp_err));
    if (!exp_err && !w) model_rd[k] = model_load(k, sz, u, ad);
    if (!exp_err && w) model_store(k, sz, ad, d);
    check("rd", rd[k], model_rd[k]);
    @(posedge Clk); #1;
    check("done_pulse", 32'(done[k]), 0);
  endtask

  // Req held high: Done every LATENCY+2 cycles and Ready only in Done cycles.
  task automatic hold_test(input int k);
    int l = LATS[k];
    int pulses = 0;
    int last = 0;
    logic [12:0] ad = 13'($urandom_range(0, 2047)) << 2;
    wait_idle(k);
    @(negedge Clk);
    req[k] = 1'b1; we[k] = 1'b0; size[k] = 2'b10; uns[k] = 1'b0; a[k] = ad; wd[k] = 32'h0;
    @(posedge Clk); #1;
    for (int c = 1; c <= 3 * (l + 2); c++) begin
      @(posedge Clk); #1;
      check("hold_ready", 32'(ready[k]), 32'(done[k]));
      if (done[k]) begin
        pulses++;
        check("hold_gap", c - last, (pulses == 1) ? l + 1 : l + 2);
        last = c;
        model_rd[k] = model_load(k, 2'b10, 1'b0, ad);
        check("hold_rd", rd[k], model_rd[k]);
      end
    end
    req[k] = 1'b0;
    check("hold_pulses", pulses, 3);
    wait_idle(k);
  endtask

  logic [31:0] r;
  logic        e;

  initial begin
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 8192; i++) mbyte[k][i] = 8'h0;
      model_rd[k] = 32'h0;
      req[k] = 1'b0; we[k] = 1'b0; uns[k] = 1'b0; size[k] = 2'b00; a[k] = '0; wd[k] = '0;
    end
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    for (int k = 0; k < NI; k++) begin
      check("rst_ready", 32'(ready[k]), 1);
      check("rst_done", 32'(done[k]), 0);
      check("rst_err", 32'(err[k]), 0);
      check("rst_rd", rd[k], 0);
    end

    access(0, 1, 2'b10, 0, 13'h010, 32'hDEADBEEF, r, e);
    access(0, 0, 2'b10, 0, 13'h010, 32'h0, r, e);
    check("plan_word", r, 32'hDEADBEEF);
    access(0, 1, 2'b00, 0, 13'h011, 32'h00000080, r, e);
    access(0, 0, 2'b00, 0, 13'h011, 32'h0, r, e);
    check("plan_sbyte", r, 32'hFFFFFF80);
    access(0, 0, 2'b00, 1, 13'h011, 32'h0, r, e);
    check("plan_ubyte", r, 32'h00000080);
    access(0, 0, 2'b01, 0, 13'h012, 32'h0, r, e);
    check("plan_shalf", r, 32'hFFFFDEAD);
    access(0, 1, 2'b10, 0, 13'h012, 32'h12345678, r, e);
    check("plan_mis_err", 32'(e), 1);
    check("plan_mis_rd", r, 32'hFFFFDEAD);
    access(0, 0, 2'b10, 0, 13'h010, 32'h0, r, e);
    check("plan_untouched", r, 32'hDEAD80EF);
    access(0, 0, 2'b11, 0, 13'h010, 32'h0, r, e);
    check("plan_size11", 32'(e), 1);
    access(0, 1, 2'b10, 0, 13'h1FFC, 32'h11111111, r, e);
    access(0, 0, 2'b10, 0, 13'h1FFC, 32'h0, r, e);
    check("plan_top", r, 32'h11111111);
    access(0, 0, 2'b10, 0, 13'h000, 32'h0, r, e);
    check("plan_word0", r, 32'h00000000);

    // Reset two cycles after accepting a store on the LATENCY=3 instance.
    wait_idle(2);
    @(negedge Clk);
    req[2] = 1'b1; we[2] = 1'b1; size[2] = 2'b10; uns[2] = 1'b0; a[2] = 13'h020; wd[2] = 32'hCAFEF00D;
    @(posedge Clk); #1;
    req[2] = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    #3 Reset = 1'b1;
    #1;
    check("midrst_ready", 32'(ready[2]), 1);
    check("midrst_done", 32'(done[2]), 0);
    check("midrst_rd", rd[2], 0);
    for (int k = 0; k < NI; k++) model_rd[k] = 32'h0;
    @(negedge Clk);
    Reset = 1'b0;
    access(2, 0, 2'b10, 0, 13'h020, 32'h0, r, e);
    check("midrst_abort", r, 32'h00000000);

    for (int k = 0; k < NI; k++) begin
      int iters = (k == 0) ? 80 : 25;
      for (int i = 0; i < iters; i++) begin
        logic [12:0] ad;
        if ($urandom_range(0, 7) == 0) ad = 13'(8192 - 64 + $urandom_range(0, 63));
        else ad = 13'($urandom_range(0, 63));
        access(k, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               ad, $urandom, r, e);
      end
      hold_test(k);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
